// File: rtl/matlib_pkg.sv
// matlib: shared types for the matrix reduction blocks
package matlib;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/mat_smax_seq_if.sv
// fixedp: fixed-point width parameter plus the common clock/reset pair
interface fixedp #(
   parameter int WIDTH = 16
) (
   input logic clk,
   input logic reset
);
   modport master (input clk, input reset);
   modport slave  (input clk, input reset);
endinterface

// File: rtl/mat_smax_seq_smax.sv
// smax: signed two-input maximum; o_b_gt is set only when i_b strictly exceeds i_a
module smax #(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0] i_a,
   input  logic signed [WIDTH-1:0] i_b,
   output logic signed [WIDTH-1:0] o_max,
   output logic                    o_b_gt
);
   always_comb begin
      o_b_gt = i_b > i_a;
      o_max  = o_b_gt ? i_b : i_a;
   end
endmodule

// File: rtl/mat_smax_seq.sv
// mat_smax_seq: sequential signed-max reduction over a captured ROWS x COLS matrix,
// one element per cycle in row-major order, reporting the earliest maximum.
module mat_smax_seq
   import matlib::*;
#(
   parameter int ROWS  = 1,
   parameter int COLS  = 1,
   parameter int WIDTH = 16
) (
   fixedp.slave                             g,
   input  logic                             start,
   input  logic [ROWS:1][COLS:1][WIDTH-1:0] a,
   output logic                             busy,
   output logic                             done,
   output logic [WIDTH-1:0]                 f,
   output logic [$clog2(ROWS+1)-1:0]        frow,
   output logic [$clog2(COLS+1)-1:0]        fcol
);
   localparam int RW = $clog2(ROWS+1);
   localparam int CW = $clog2(COLS+1);
   localparam int N  = ROWS * COLS;
   state_t                           r_state, w_next;
   logic [ROWS:1][COLS:1][WIDTH-1:0] r_a;
   logic signed [WIDTH-1:0]          r_best, w_cur, w_max;
   logic [RW-1:0]                    r_row, r_brow;
   logic [CW-1:0]                    r_col, r_bcol;
   logic                             w_gt, w_accept, w_last, w_wrap;
   assign w_cur    = r_a[r_row][r_col];
   assign w_accept = r_state == IDLE && start;
   assign w_wrap   = r_col == CW'(COLS);
   assign w_last   = r_row == RW'(ROWS) && w_wrap;
   smax #(.WIDTH(WIDTH)) u_smax (
      .i_a    (r_best),
      .i_b    (w_cur),
      .o_max  (w_max),
      .o_b_gt (w_gt)
   );
   always_ff @(posedge g.clk) begin
      if (g.reset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (N == 1) w_next = DONE;
               else        w_next = SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   // the first element seeds best, so scanning starts at the second element
   always_ff @(posedge g.clk) begin
      if (g.reset) begin
         r_a    <= '0;
         r_best <= '0;
         r_brow <= '0;
         r_bcol <= '0;
         r_row  <= '0;
         r_col  <= '0;
         f      <= '0;
         frow   <= '0;
         fcol   <= '0;
      end else if (w_accept) begin
         r_a    <= a;
         r_best <= a[1][1];
         r_brow <= RW'(1);
         r_bcol <= CW'(1);
         r_row  <= COLS == 1 ? RW'(2) : RW'(1);
         r_col  <= COLS == 1 ? CW'(1) : CW'(2);
         if (N == 1) begin
            f    <= a[1][1];
            frow <= RW'(1);
            fcol <= CW'(1);
         end
      end else if (r_state == SCAN) begin
         r_best <= w_max;
         if (w_gt) begin
            r_brow <= r_row;
            r_bcol <= r_col;
         end
         r_row <= w_wrap ? r_row + RW'(1) : r_row;
         r_col <= w_wrap ? CW'(1) : r_col + CW'(1);
         if (w_last) begin
            f    <= w_max;
            frow <= w_gt ? r_row : r_brow;
            fcol <= w_gt ? r_col : r_bcol;
         end
      end
   end
endmodule

// File: tb/tb_mat_smax_seq.sv
// tb_mat_smax_seq: directed checks of the 2x3 and 1x1 signed-max reductions
module tb_mat_smax_seq;
   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   start = 1'b0, start1 = 1'b0;
   logic [2:1][3:1][15:0]  a = '0;
   logic [1:1][1:1][15:0]  a1 = '0;
   logic                   busy, done, busy1, done1;
   logic [15:0]            f, f1;
   logic [1:0]             frow, fcol;
   logic                   frow1, fcol1;
   int                     n_chk = 0, n_pass = 0;
   int                     nd, d1, d2;
   logic [15:0]            rf1, rf2;
   logic [1:0]             rr1, rc1, rr2, rc2;
   always #5 clk = ~clk;
   fixedp #(.WIDTH(16)) g (.clk(clk), .reset(rst));
   mat_smax_seq #(.ROWS(2), .COLS(3), .WIDTH(16)) dut (
      .g(g), .start(start), .a(a), .busy(busy), .done(done),
      .f(f), .frow(frow), .fcol(fcol)
   );
   mat_smax_seq #(.ROWS(1), .COLS(1), .WIDTH(16)) dut1 (
      .g(g), .start(start1), .a(a1), .busy(busy1), .done(done1),
      .f(f1), .frow(frow1), .fcol(fcol1)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic load(input logic [15:0] m11, m12, m13, m21, m22, m23);
      a[1][1] = m11; a[1][2] = m12; a[1][3] = m13;
      a[2][1] = m21; a[2][2] = m22; a[2][3] = m23;
   endtask
   task automatic run(input string tag, input logic [15:0] ef, input int er, input int ec);
      int lat = 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'd6);
      check({tag, "_f"}, 32'(f), 32'(ef));
      check({tag, "_frow"}, 32'(frow), 32'(er));
      check({tag, "_fcol"}, 32'(fcol), 32'(ec));
      @(negedge clk);
      check({tag, "_done_off"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask
   initial begin
      start = 1'b1;
      start1 = 1'b1;
      load(16'd1, 16'd5, 16'hFFFD, 16'd7, 16'd2, 16'hFFF8);
      a1[1][1] = 16'h1234;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_f", 32'(f), 32'd0);
      check("rst_frow", 32'(frow), 32'd0);
      check("rst_fcol", 32'(fcol), 32'd0);
      check("rst_f1", 32'(f1), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      start1 = 1'b0;
      @(negedge clk);
      check("start_in_rst", 32'(busy), 32'd0);
      check("start_in_rst1", 32'(busy1), 32'd0);
      run("basic", 16'd7, 2, 1);
      repeat (3) @(negedge clk);
      check("hold_f", 32'(f), 32'd7);
      check("hold_pos", 32'({frow, fcol}), 32'({2'd2, 2'd1}));
      load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      run("tie", 16'hFFFF, 1, 1);
      load(16'h8000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h8001, 16'hFFFF);
      run("signed", 16'h7FFF, 1, 3);
      load(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'd100);
      run("last", 16'd100, 2, 3);
      load(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
      run("allmin", 16'h8000, 1, 1);
      load(16'd3, 16'd9, 16'd9, 16'd9, 16'hFFFF, 16'd0);
      run("mid", 16'd9, 1, 2);
      // start held for 10 cycles while a keeps changing after acceptance
      nd = 0; d1 = 0; d2 = 0;
      rf1 = '0; rf2 = '0; rr1 = '0; rc1 = '0; rr2 = '0; rc2 = '0;
      load(16'd1, 16'd5, 16'hFFFD, 16'd7, 16'd2, 16'hFFF8);
      @(negedge clk) start = 1'b1;
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) begin
               d1 = j; rf1 = f; rr1 = frow; rc1 = fcol;
            end else begin
               d2 = j; rf2 = f; rr2 = frow; rc2 = fcol;
            end
         end
         if (j >= 10) start = 1'b0;
         else begin
            for (int r = 1; r <= 2; r++)
               for (int c = 1; c <= 3; c++)
                  a[r][c] = 16'(j * 1000);
            if (j == 7) a[2][2] = 16'd9999;
         end
      end
      check("hold_ndone", 32'(nd), 32'd2);
      check("hold_d1", 32'(d1), 32'd6);
      check("hold_f1", 32'(rf1), 32'd7);
      check("hold_pos1", 32'({rr1, rc1}), 32'({2'd2, 2'd1}));
      check("hold_d2", 32'(d2), 32'd13);
      check("hold_f2", 32'(rf2), 32'd9999);
      check("hold_pos2", 32'({rr2, rc2}), 32'({2'd2, 2'd2}));
      check("hold_idle", 32'(busy), 32'd0);
      // reset pulse during the third SCAN cycle aborts the reduction
      load(16'd1, 16'd5, 16'hFFFD, 16'd7, 16'd2, 16'hFFF8);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_f", 32'(f), 32'd0);
      check("abort_pos", 32'({frow, fcol}), 32'd0);
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("abort_nodone", 32'(nd), 32'd0);
      load(16'd3, 16'd9, 16'd9, 16'd9, 16'hFFFF, 16'd0);
      run("after_rst", 16'd9, 1, 2);
      a1[1][1] = 16'h8000;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      check("one_done", 32'(done1), 32'd1);
      check("one_busy", 32'(busy1), 32'd1);
      check("one_f", 32'(f1), 32'h8000);
      check("one_pos", 32'({frow1, fcol1}), 32'({1'b1, 1'b1}));
      @(negedge clk);
      check("one_done_off", 32'(done1), 32'd0);
      check("one_idle", 32'(busy1), 32'd0);
      check("one_hold", 32'(f1), 32'h8000);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
